tweakey_check: RTL



---
 rtl/tweakey_check_pkg.sv | 24 ++
 rtl/tweakey_check_toeplitz_step.sv | 25 ++
 rtl/tweakey_check.sv | 139 +++++++++++++
 3 files changed

// File: rtl/tweakey_check_pkg.sv
// Shared definitions for the tweakey generator / checker pair.
// Default hash geometry, tweakey half-select offsets and the checker FSM
// state type. The generator and the checker both import this package so
// they agree on widths and on which half of the tweakey is which.
package tweakey_check_pkg;

  localparam int unsigned IN_LEN_DEF = 128;
  localparam int unsigned DIM_DEF    = 128;
  localparam int unsigned KLEN_DEF   = IN_LEN_DEF + DIM_DEF - 1;

  // Low half of the tweakey starts at bit 0; high half starts at DIM.
  localparam int unsigned TK_LO_OFF  = 0;

  function automatic int unsigned tk_hi_off(input int unsigned dim);
    return TK_LO_OFF + dim;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/tweakey_check_toeplitz_step.sv
// One STEP-wide slice of a GF(2) Toeplitz matrix-vector product.
// Ports:
//   key_win  : DIM+STEP-1 key bits, already aligned so column s of this
//              slice is key_win[DIM-1-k+s] for output bit k
//   tw_bits  : STEP tweak bits selecting which columns contribute
//   contrib  : XOR of the selected columns (DIM bits)
module toeplitz_step #(
  parameter int unsigned DIM  = 128,
  parameter int unsigned STEP = 8
) (
  input  logic [DIM+STEP-2:0] key_win,
  input  logic [STEP-1:0]     tw_bits,
  output logic [DIM-1:0]      contrib
);

  always_comb begin
    contrib = '0;
    for (int unsigned s = 0; s < STEP; s++) begin
      for (int unsigned k = 0; k < DIM; k++) begin
        contrib[k] = contrib[k] ^ (tw_bits[s] & key_win[DIM-1-k+s]);
      end
    end
  end

endmodule

// File: rtl/tweakey_check.sv
// Sequential tweakey checker: recomputes both Toeplitz hash halves of a
// tweak, STEP tweak bits per cycle, and flags whether the result equals a
// candidate tweakey.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_valid / in_ready   : request handshake (in_ready = idle)
//   tweak                 : IN_LEN-bit hash input
//   key                   : {high-half key, low-half key}, KLEN bits each
//   tk_exp                : candidate tweakey
//   out_valid / out_ready : result handshake
//   tk_out                : recomputed tweakey {high half, low half}
//   match                 : tk_out equals the captured tk_exp
module tweakey_check
  import tweakey_check_pkg::*;
#(
  parameter int unsigned IN_LEN = IN_LEN_DEF,
  parameter int unsigned DIM    = DIM_DEF,
  parameter int unsigned STEP   = 8,
  parameter int unsigned KLEN   = IN_LEN + DIM - 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_LEN-1:0]   tweak,
  input  logic [2*KLEN-1:0]   key,
  input  logic [2*DIM-1:0]    tk_exp,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DIM-1:0]    tk_out,
  output logic                match
);

  localparam int unsigned NSTEP  = IN_LEN / STEP;
  localparam int unsigned CNT_W  = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam int unsigned HI_OFF = tk_hi_off(DIM);

  state_t              state_q, state_d;
  logic [IN_LEN-1:0]   tw_q;
  logic [KLEN-1:0]     klo_q, khi_q;
  logic [2*DIM-1:0]    exp_q;
  logic [DIM-1:0]      acc_lo_q, acc_hi_q;
  logic [DIM-1:0]      contrib_lo, contrib_hi;
  logic [DIM-1:0]      acc_lo_nxt, acc_hi_nxt;
  logic [2*DIM-1:0]    tk_nxt;
  logic [CNT_W-1:0]    cnt_q;
  logic                match_q;
  logic                last_step;

  // Keys shift right by STEP every RUN cycle, so the columns needed for the
  // current tweak bits always sit in the low DIM+STEP-1 key bits.
  toeplitz_step #(.DIM(DIM), .STEP(STEP)) u_step_lo (
    .key_win (klo_q[DIM+STEP-2:0]),
    .tw_bits (tw_q[STEP-1:0]),
    .contrib (contrib_lo)
  );

  toeplitz_step #(.DIM(DIM), .STEP(STEP)) u_step_hi (
    .key_win (khi_q[DIM+STEP-2:0]),
    .tw_bits (tw_q[STEP-1:0]),
    .contrib (contrib_hi)
  );

  always_comb begin
    acc_lo_nxt = acc_lo_q ^ contrib_lo;
    acc_hi_nxt = acc_hi_q ^ contrib_hi;
    tk_nxt     = '0;
    tk_nxt[TK_LO_OFF +: DIM] = acc_lo_nxt;
    tk_nxt[HI_OFF    +: DIM] = acc_hi_nxt;
    tk_out     = '0;
    tk_out[TK_LO_OFF +: DIM] = acc_lo_q;
    tk_out[HI_OFF    +: DIM] = acc_hi_q;
  end

  assign last_step = (cnt_q == CNT_W'(NSTEP - 1));
  assign match     = match_q;

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (last_step) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      tw_q     <= '0;
      klo_q    <= '0;
      khi_q    <= '0;
      exp_q    <= '0;
      acc_lo_q <= '0;
      acc_hi_q <= '0;
      cnt_q    <= '0;
      match_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            tw_q     <= tweak;
            klo_q    <= key[KLEN-1:0];
            khi_q    <= key[2*KLEN-1:KLEN];
            exp_q    <= tk_exp;
            acc_lo_q <= '0;
            acc_hi_q <= '0;
            cnt_q    <= '0;
          end
        end
        ST_RUN: begin
          tw_q     <= tw_q >> STEP;
          klo_q    <= klo_q >> STEP;
          khi_q    <= khi_q >> STEP;
          acc_lo_q <= acc_lo_nxt;
          acc_hi_q <= acc_hi_nxt;
          cnt_q    <= cnt_q + CNT_W'(1);
          // Compare against the final accumulator value so match is
          // already valid in the first DONE cycle.
          if (last_step) match_q <= (tk_nxt == exp_q);
        end
        default: ;
      endcase
    end
  end

endmodule
